// File: rtl/pad_bidir_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : pad_bidir_array_if
//  Description : Pin-side / node-side signal bundle for pad_bidir_array.
//                The master side is the pin world plus node mesh that drives
//                levels and voltages; the slave side is the pad model.
//  Revision    : 1.0  initial release
// ============================================================================
interface pad_bidir_array_if #(
  parameter int N = 8,
  parameter int W = 16
);
  logic [N-1:0]   p_i;       // external pad level
  logic [N-1:0]   p_en;      // external driver enabled
  logic [N*W-1:0] v;         // pad node voltages, channel c at [c*W +: W]
  logic [N*W-1:0] oe_v;      // output-enable node voltages
  logic [N-1:0]   cont_clr;  // per-channel contention flag clear
  logic [N*W-1:0] i;         // current injected into each pad node
  logic [N-1:0]   p_o;       // filtered chip output level
  logic [N-1:0]   p_t;       // 1 = chip drives pad
  logic [N-1:0]   cont;      // sticky contention flags

  modport master (
    output p_i, p_en, v, oe_v, cont_clr,
    input  i, p_o, p_t, cont
  );

  modport slave (
    input  p_i, p_en, v, oe_v, cont_clr,
    output i, p_o, p_t, cont
  );
endinterface
`default_nettype wire

// File: rtl/pad_bidir_array.sv
`default_nettype none
// ============================================================================
//  Module      : pad_bidir_array
//  Description : N-channel bidirectional pad model for the switch-level sim.
//                Per channel: registered signed current injection scaled from
//                (pad voltage - node voltage), hysteresis + debounce sensing
//                of the pad node into p_o, hysteresis sensing of the OE node
//                into p_t, and a sticky driver-contention flag.
//  Revision    : 1.0  initial release
// ============================================================================
module pad_bidir_array #(
  parameter int          W          = 16,
  parameter int          N          = 8,
  parameter int          SHIFT      = 4,
  parameter int          HI         = 2**(W-2),
  parameter int          LO         = -(2**(W-2)),
  parameter int          VTH_HI     = HI/2,
  parameter int          VTH_LO     = LO/2,
  parameter int          SETTLE     = 3,
  parameter logic [N-1:0] BIDIR_MASK = {N{1'b1}}
) (
  input  logic               eclk,
  input  logic               erst_n,
  pad_bidir_array_if.slave   bus
);

  // Debounce counter wide enough to hold SETTLE-1 with margin.
  localparam int CW = $clog2(SETTLE) + 1;

  localparam logic [CW-1:0]       CNT_LAST = CW'(SETTLE - 1);
  localparam logic signed [W-1:0] HI_V     = HI[W-1:0];
  localparam logic signed [W-1:0] LO_V     = LO[W-1:0];
  localparam logic signed [W-1:0] TH_HI_V  = VTH_HI[W-1:0];
  localparam logic signed [W-1:0] TH_LO_V  = VTH_LO[W-1:0];

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic signed [W-1:0] v_c;
    logic signed [W-1:0] oe_c;
    logic signed [W-1:0] vp;
    logic signed [W:0]   dv;
    logic signed [W-1:0] drv;
    logic                raw;
    logic                oe_raw;
    logic [CW-1:0]       cnt;
    logic signed [W-1:0] i_q;
    logic                po_q;
    logic                pt_q;
    logic                cont_q;

    assign v_c  = bus.v[c*W +: W];
    assign oe_c = bus.oe_v[c*W +: W];

    // Voltage difference at W+1 bits so HI-LO extremes never wrap; the
    // arithmetic shift by SHIFT>=1 brings it back into W bits losslessly.
    assign vp  = bus.p_i[c] ? HI_V : LO_V;
    assign dv  = {vp[W-1], vp} - {v_c[W-1], v_c};
    assign drv = W'(dv >>> SHIFT);

    // Hysteresis: outside the band the level is forced, inside it holds.
    assign raw    = (v_c  >= TH_HI_V) ? 1'b1 :
                    (v_c  <= TH_LO_V) ? 1'b0 : po_q;
    assign oe_raw = (oe_c >= TH_HI_V) ? 1'b1 :
                    (oe_c <= TH_LO_V) ? 1'b0 : pt_q;

    // Current injection: only when the pin drives and the chip does not.
    always_ff @(posedge eclk) begin
      if (!erst_n) begin
        i_q <= '0;
      end else begin
        i_q <= (bus.p_en[c] && !pt_q) ? drv : '0;
      end
    end

    // Debounce: p_o follows raw only after SETTLE consecutive differing edges.
    always_ff @(posedge eclk) begin
      if (!erst_n) begin
        po_q <= 1'b0;
        cnt  <= '0;
      end else if (raw == po_q) begin
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        po_q <= raw;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end

    // Tristate enable: single-cycle, masked off for input-only channels.
    always_ff @(posedge eclk) begin
      if (!erst_n) begin
        pt_q <= 1'b0;
      end else begin
        pt_q <= BIDIR_MASK[c] & oe_raw;
      end
    end

    // Contention flag: sticky, a new contention wins over a clear.
    always_ff @(posedge eclk) begin
      if (!erst_n) begin
        cont_q <= 1'b0;
      end else begin
        cont_q <= (bus.p_en[c] & pt_q) | (cont_q & ~bus.cont_clr[c]);
      end
    end

    assign bus.i[c*W +: W] = i_q;
    assign bus.p_o[c]      = po_q;
    assign bus.p_t[c]      = pt_q;
    assign bus.cont[c]     = cont_q;
  end

endmodule
`default_nettype wire
